key_onehot_capture: RTL and testbench

Front-end key capture stage that turns 15 raw, bouncing push-button lines into a clean one-hot key code for the address encoder. It drives the encoder's 15-bit one-hot input directly: bit 14 encodes index 0, and bits 0..13 encode indices 1..14. The block synchronizes and debounces the inputs and accepts exactly one key at a time. Press and release events are reported as single-cycle pulses for the downstream sequencing logic.

---
 rtl/key_onehot_capture.sv | 139 +++++++++++++
 tb/tb_key_onehot_capture.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_onehot_capture.sv
// Push-button front end: two-flop synchronizer, shared-counter debounce and a
// single-key acceptance FSM that drives the address encoder's one-hot input.
module key_onehot_capture #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] key_raw_i,
  output logic [14:0] addr_onehot_o,
  output logic        key_valid_o,
  output logic        key_press_o,
  output logic        key_release_o,
  output logic        multi_err_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLockout
  } state_e;

  logic [14:0]      s1_q, s2_q;
  logic [14:0]      cand_q, cand_d;
  logic [14:0]      stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             oh;

  state_e           state_q;
  logic [14:0]      addr_q;
  logic             valid_q, press_q, release_q, merr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= key_raw_i;
      s2_q <= s1_q;
    end
  end

  // One counter for the whole vector: any bit change restarts the window,
  // and the count saturates once the candidate has been stable long enough.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign oh = (stable_q != '0) && ((stable_q & (stable_q - 15'd1)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      merr_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (oh) begin
            state_q <= StPressed;
            addr_q  <= stable_q;
            valid_q <= 1'b1;
            press_q <= 1'b1;
          end else if (stable_q != '0) begin
            state_q <= StLockout;
            merr_q  <= 1'b1;
          end
        end
        StPressed: begin
          if (stable_q == addr_q) begin
            state_q <= StPressed;
          end else if (stable_q == '0) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            // Added key or slide to another key: drop the held key and lock out.
            state_q   <= StLockout;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b1;
            merr_q    <= 1'b1;
          end
        end
        StLockout: begin
          addr_q  <= '0;
          valid_q <= 1'b0;
          if (stable_q == '0) begin
            state_q <= StIdle;
            merr_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          addr_q  <= '0;
          valid_q <= 1'b0;
          merr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_onehot_o = addr_q;
  assign key_valid_o   = valid_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign multi_err_o   = merr_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Scoreboard bench for key_onehot_capture: stimulus queues expected output
// changes with their cycle number; a negedge monitor compares each change.
module tb_key_onehot_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] key_raw = 15'h7FFF;
  logic [14:0] addr_onehot;
  logic        key_valid, key_press, key_release, multi_err;

  key_onehot_capture #(
    .DB_CYCLES(4),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_raw_i    (key_raw),
    .addr_onehot_o(addr_onehot),
    .key_valid_o  (key_valid),
    .key_press_o  (key_press),
    .key_release_o(key_release),
    .multi_err_o  (multi_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [18:0] t;  // {addr, valid, press, release, multi_err}
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [18:0] prev = '0;

  // A key change made just after edge N is first sampled at N+1; outputs move at N+8.
  localparam int Lat = 8;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [14:0] a, input logic v, input logic p,
                      input logic r, input logic m);
    ev_t e;
    e.c = c;
    e.t = {a, v, p, r, m};
    q.push_back(e);
  endtask

  task automatic exp_press(input int c, input logic [14:0] a);
    push(c, a, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c + 1, a, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_rel(input int c, input logic m);
    push(c, 15'h0, 1'b0, 1'b0, 1'b1, m);
    push(c + 1, 15'h0, 1'b0, 1'b0, 1'b0, m);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [14:0] v, input int hold);
    key_raw = v;
    step(hold);
  endtask

  always @(negedge clk) begin
    logic [18:0] cur;
    ev_t         e;
    cur = {addr_onehot, key_valid, key_press, key_release, multi_err};
    check("inv_press_release", {31'b0, key_press & key_release}, 32'd0);
    check("inv_valid", {31'b0, key_valid}, {31'b0, addr_onehot != 15'h0});
    if (q.size() > 0 && q[0].c < cyc) begin
      e = q.pop_front();
      check("missed_event_cycle", cyc, e.c);
    end
    if (cur != prev) begin
      if (q.size() == 0) begin
        check("unexpected_change", {13'b0, cur}, {13'b0, prev});
      end else begin
        e = q.pop_front();
        check("event_cycle", cyc, e.c);
        check("event_outputs", {13'b0, cur}, {13'b0, e.t});
      end
    end
    prev = cur;
  end

  initial begin
    // 1: reset with every key held; outputs zero, then lockout after release.
    step(3);
    check("reset_addr", {17'b0, addr_onehot}, 32'h0);
    check("reset_flags", {28'b0, key_valid, key_press, key_release, multi_err}, 32'h0);
    rst_n = 1'b1;
    push(cyc + Lat, 15'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(12);
    push(cyc + Lat, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_key(15'h0000, 12);

    // 2: clean press and release of bit 14.
    exp_press(cyc + Lat, 15'h4000);
    set_key(15'h4000, 20);
    exp_rel(cyc + Lat, 1'b0);
    set_key(15'h0000, 12);

    // 3: bounce on bit 3 with 1/2/3-cycle periods, then held.
    set_key(15'h0008, 1);
    set_key(15'h0000, 1);
    set_key(15'h0008, 2);
    set_key(15'h0000, 2);
    set_key(15'h0008, 3);
    set_key(15'h0000, 3);
    exp_press(cyc + Lat, 15'h0008);
    set_key(15'h0008, 12);
    exp_rel(cyc + Lat, 1'b0);
    set_key(15'h0000, 12);

    // 4: second key added while bit 0 held.
    exp_press(cyc + Lat, 15'h0001);
    set_key(15'h0001, 12);
    exp_rel(cyc + Lat, 1'b1);
    set_key(15'h0021, 12);
    set_key(15'h0020, 12);
    check("lockout_hold", {31'b0, multi_err}, 32'd1);
    push(cyc + Lat, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_key(15'h0000, 12);

    // 5: slide from bit 13 to bit 12, then a fresh press of bit 12.
    exp_press(cyc + Lat, 15'h2000);
    set_key(15'h2000, 12);
    exp_rel(cyc + Lat, 1'b1);
    set_key(15'h1000, 12);
    push(cyc + Lat, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_key(15'h0000, 12);
    exp_press(cyc + Lat, 15'h1000);
    set_key(15'h1000, 12);
    exp_rel(cyc + Lat, 1'b0);
    set_key(15'h0000, 12);

    // 6: asynchronous reset pulse mid-press of bit 7.
    exp_press(cyc + Lat, 15'h0080);
    set_key(15'h0080, 12);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_addr", {17'b0, addr_onehot}, 32'h0);
    check("async_reset_valid", {31'b0, key_valid}, 32'd0);
    push(cyc, 15'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_press(cyc + Lat, 15'h0080);
    #1 rst_n = 1'b1;
    step(12);
    exp_rel(cyc + Lat, 1'b0);
    set_key(15'h0000, 12);

    check("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
